// File: rtl/mod_counter_pkg.sv
// Shared op-codes and FSM state encoding for the modulo-N counter sequencer.
package mod_counter_pkg;

  localparam logic [1:0] OP_CLEAR  = 2'b00;
  localparam logic [1:0] OP_PRESET = 2'b01;
  localparam logic [1:0] OP_RUN    = 2'b10;
  localparam logic [1:0] OP_LOAD   = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mod_counter_core.sv
// Modulo-MODULUS counter datapath: clear > load > enable, up or down by dir.
module mod_counter_core #(
  parameter int MODULUS = 13,
  parameter int WIDTH   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] count,
  output logic             wrap_evt
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  // Flags the step that crosses the modulus boundary, one cycle before count shows it.
  assign wrap_evt = en && (dir ? (count == '0) : (count == MAX_CNT));

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      if (dir) count <= (count == '0) ? MAX_CNT : count - 1'b1;
      else     count <= (count == MAX_CNT) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/mod_counter_ctrl.sv
// Command sequencer around mod_counter_core. Optional down-count run via MODCTR_DOWN_EN.
//   state   | meaning
//   ST_IDLE | ready for a command; CLEAR/PRESET/LOAD complete here in one edge
//   ST_RUN  | stepping the counter once per edge until remaining hits zero or halt
module mod_counter_ctrl
  import mod_counter_pkg::*;
#(
  parameter int MODULUS      = 13,
  parameter int WIDTH        = 4,
  parameter int PRESET_VALUE = 9,
  parameter int ARG_W        = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [ARG_W-1:0] cmd_arg,
  input  logic             halt,
`ifdef MODCTR_DOWN_EN
  input  logic             down,
`endif
  output logic [WIDTH-1:0] counter,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  localparam logic [ARG_W-1:0] MOD_ARG    = ARG_W'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_CNT    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] PRESET_CNT = WIDTH'(PRESET_VALUE);

  state_t           state, state_nxt;
  logic [ARG_W-1:0] remaining, remaining_nxt;
  logic             dir_q, dir_nxt;
  logic             done_nxt;
  logic             clr, load, en;
  logic [WIDTH-1:0] load_val;
  logic             wrap_evt;
  logic             run_dir;

`ifdef MODCTR_DOWN_EN
  assign run_dir = down;
`else
  assign run_dir = 1'b0;
`endif

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state == ST_RUN);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      dir_q     <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      dir_q     <= dir_nxt;
      done      <= done_nxt;
      wrap      <= wrap_evt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    dir_nxt       = dir_q;
    done_nxt      = 1'b0;
    clr           = 1'b0;
    load          = 1'b0;
    load_val      = '0;
    en            = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_CLEAR: begin
              clr      = 1'b1;
              done_nxt = 1'b1;
            end
            OP_PRESET: begin
              load     = 1'b1;
              load_val = PRESET_CNT;
              done_nxt = 1'b1;
            end
            OP_LOAD: begin
              load     = 1'b1;
              // Out-of-range values saturate rather than alias into the count range.
              load_val = (cmd_arg < MOD_ARG) ? cmd_arg[WIDTH-1:0] : MAX_CNT;
              done_nxt = 1'b1;
            end
            default: begin
              if (cmd_arg == '0) begin
                done_nxt = 1'b1;
              end else begin
                remaining_nxt = cmd_arg;
                dir_nxt       = run_dir;
                state_nxt     = ST_RUN;
              end
            end
          endcase
        end
      end
      ST_RUN: begin
        if (halt) begin
          remaining_nxt = '0;
          state_nxt     = ST_IDLE;
        end else begin
          en            = 1'b1;
          remaining_nxt = remaining - 1'b1;
          if (remaining == ARG_W'(1)) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  mod_counter_core #(
    .MODULUS (MODULUS),
    .WIDTH   (WIDTH)
  ) u_core (
    .clock    (clock),
    .reset    (reset),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .dir      (dir_q),
    .count    (counter),
    .wrap_evt (wrap_evt)
  );

endmodule
